// File: rtl/wb_pkg.sv
// Shared types for the writeback queue.
// Entry layout and default queue depth.
package wb_pkg;
  localparam int WB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over queued writebacks.
// Age is measured from the read pointer.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]         rd_ptr,
  input  logic [CW-1:0]         count,
  input  logic [4:0]            rs_addr,
  output logic                  hit,
  output logic [31:0]           fwd
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count &&
          rs_addr != 5'd0 &&
          entries[idx].addr == rs_addr) begin
        hit = 1'b1;
        fwd = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue feeding the register file write port.
// Pending writes are forwarded to decode source lookups.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_valid,
  output logic          o_wb_ready,
  input  logic [4:0]    i_wb_addr,
  input  logic [31:0]   i_wb_data,
  input  logic          i_drain_en,
  output logic          o_rd_wren,
  output logic [4:0]    o_rd_addr,
  output logic [31:0]   o_rd_data,
  input  logic [4:0]    i_rs1_addr,
  input  logic [4:0]    i_rs2_addr,
  output logic          o_rs1_hit,
  output logic          o_rs2_hit,
  output logic [31:0]   o_rs1_fwd,
  output logic [31:0]   o_rs2_fwd,
  output logic [CW-1:0] o_count
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          empty;

  assign empty      = (count == '0);
  assign o_wb_ready = (count < CW'(DEPTH));
  assign o_rd_wren  = !empty && i_drain_en;
  assign pop        = o_rd_wren;
  // x0 writes complete the handshake but are dropped.
  assign push       = i_wb_valid && o_wb_ready &&
                      (i_wb_addr != 5'd0);
  assign o_count    = count;

  assign o_rd_addr = empty ? 5'd0  : mem[rd_ptr].addr;
  assign o_rd_data = empty ? 32'd0 : mem[rd_ptr].data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= '{addr: i_wb_addr, data: i_wb_data};
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_rs1 (
    .entries (mem),
    .rd_ptr  (rd_ptr),
    .count   (count),
    .rs_addr (i_rs1_addr),
    .hit     (o_rs1_hit),
    .fwd     (o_rs1_fwd)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_rs2 (
    .entries (mem),
    .rd_ptr  (rd_ptr),
    .count   (count),
    .rs_addr (i_rs2_addr),
    .hit     (o_rs2_hit),
    .fwd     (o_rs2_fwd)
  );

endmodule
